// File: rtl/state_trace_monitor.sv
// Observes a 2-bit JK state stream: per-state visit counters, transition
// legality checking with a sticky error flag, and a 00,11,01,10 detector.
module state_trace_monitor #(
  parameter int unsigned CW = 8
) (
  input  logic          Clk,
  input  logic          rst,
  input  logic          FA,
  input  logic          FB,
  input  logic          en,
  input  logic          clr,
  input  logic [1:0]    rd_sel,
  output logic [CW-1:0] rd_cnt,
  output logic [CW-1:0] err_cnt,
  output logic          trans_err,
  output logic          seq_det
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G1   = 2'd1;
  localparam logic [1:0] G2   = 2'd2;
  localparam logic [1:0] G3   = 2'd3;

  localparam logic [CW-1:0] MAX = '1;

  logic [1:0]    s;
  logic          acc;
  logic          legal;
  logic          illegal;

  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [CW-1:0] rd_q, rd_d;
  logic [CW-1:0] err_q, err_d;
  logic          terr_q, terr_d;
  logic          seq_q, seq_d;
  logic [1:0]    p_q, p_d;
  logic          pv_q, pv_d;
  logic [1:0]    det_q, det_d;

  assign s   = {FA, FB};
  assign acc = en & ~clr;

  always_comb begin
    legal = 1'b0;
    unique case (p_q)
      2'b00: legal = (s == 2'b00) || (s == 2'b11);
      2'b01: legal = (s == 2'b01) || (s == 2'b10);
      2'b10: legal = (s == 2'b00) || (s == 2'b10);
      2'b11: legal = (s == 2'b01) || (s == 2'b11);
      default: legal = 1'b0;
    endcase
  end

  // First sample after reset/clear has no predecessor to check against.
  assign illegal = acc & pv_q & ~legal;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (clr) begin
      for (int i = 0; i < 4; i++) begin
        cnt_d[i] = '0;
      end
    end else if (en && cnt_q[s] != MAX) begin
      cnt_d[s] = cnt_q[s] + 1'b1;
    end
  end

  always_comb begin
    rd_d   = clr ? '0 : cnt_q[rd_sel];
    err_d  = err_q;
    terr_d = terr_q | illegal;
    p_d    = acc ? s : p_q;
    pv_d   = pv_q | acc;
    if (illegal && err_q != MAX) begin
      err_d = err_q + 1'b1;
    end
    if (clr) begin
      err_d  = '0;
      terr_d = 1'b0;
      pv_d   = 1'b0;
    end
  end

  always_comb begin
    det_d = det_q;
    seq_d = 1'b0;
    if (clr) begin
      det_d = IDLE;
    end else if (en) begin
      det_d = IDLE;
      unique case (1'b1)
        (s == 2'b00): det_d = G1;
        (det_q == G1 && s == 2'b11): det_d = G2;
        (det_q == G2 && s == 2'b01): det_d = G3;
        (det_q == G3 && s == 2'b10): seq_d = 1'b1;
        default: det_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      rd_q   <= '0;
      err_q  <= '0;
      terr_q <= 1'b0;
      seq_q  <= 1'b0;
      p_q    <= 2'b00;
      pv_q   <= 1'b0;
      det_q  <= IDLE;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      rd_q   <= rd_d;
      err_q  <= err_d;
      terr_q <= terr_d;
      seq_q  <= seq_d;
      p_q    <= p_d;
      pv_q   <= pv_d;
      det_q  <= det_d;
    end
  end

  assign rd_cnt    = rd_q;
  assign err_cnt   = err_q;
  assign trans_err = terr_q;
  assign seq_det   = seq_q;

endmodule

// File: doc/state_trace_monitor.md
STATE_TRACE_MONITOR -- requirements
Module: state_trace_monitor

Interface
REQ-001 SHALL have parameter: CW, 8, width of every counter output (valid range 2..16).
REQ-002 SHALL have port: Clk  input  1  rising-edge clock, shared with the upstream JK state machine.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: FA  input  1  upstream state bit A (MSB of state S={FA,FB}).
REQ-005 SHALL have port: FB  input  1  upstream state bit B (LSB of S).
REQ-006 SHALL have port: en  input  1  sample enable; S sampled on a rising Clk edge only when en=1.
REQ-007 SHALL have port: clr  input  1  synchronous clear of all monitor state.
REQ-008 SHALL have port: rd_sel  input  2  selects the visit counter (state 00..11) shown on rd_cnt.
REQ-009 SHALL have port: rd_cnt  output  CW  registered visit count of state rd_sel.
REQ-010 SHALL have port: err_cnt  output  CW  count of illegal transitions.
REQ-011 SHALL have port: trans_err  output  1  sticky illegal-transition flag.
REQ-012 SHALL have port: seq_det  output  1  one-cycle pulse on detection of sequence 00,11,01,10.

Function
REQ-013 Legal transitions (prev->cur) SHALL be exactly: 00->{00,11}; 01->{01,10}; 10->{00,10}; 11->{01,11}; the other 8 pairs are illegal.
REQ-014 Each accepted sample (en=1, clr=0) SHALL increment visit counter[S] by 1, saturating at 2^CW-1 (no wrap).
REQ-015 Monitor SHALL hold prev state register P and flag prev_valid; an accepted sample SHALL load P<=S and set prev_valid=1.
REQ-016 Legality check SHALL run only when prev_valid=1; the first accepted sample after reset/clr is never flagged.
REQ-017 Illegal accepted sample SHALL set trans_err=1 and increment err_cnt (saturating), both visible in the cycle after the sampling edge.
REQ-018 trans_err SHALL remain 1 until rst or clr, regardless of later legal samples.
REQ-019 Sequence detector SHALL be an FSM with states IDLE, G1 (seen 00), G2 (seen 00,11), G3 (seen 00,11,01), advancing only on accepted samples.
REQ-020 From any detector state, sample 00 SHALL go to G1.
REQ-021 Transitions SHALL be: G1 + 11 -> G2; G2 + 01 -> G3; G3 + 10 -> IDLE with seq_det=1; any other non-00 sample -> IDLE.
REQ-022 seq_det SHALL be registered, high for exactly one cycle after the edge sampling the completing 10, low otherwise.
REQ-023 en=0 SHALL freeze counters, P, prev_valid, and detector state; seq_det SHALL be 0.
REQ-024 rd_cnt SHALL equal counter[rd_sel] as of the previous edge (1-cycle read latency); a counter updated at the same edge shows its new value one cycle later.
REQ-025 clr=1 SHALL, at the edge: zero all visit counters, err_cnt, trans_err, seq_det, rd_cnt; clear prev_valid; set detector to IDLE.
REQ-026 clr and en both 1 SHALL resolve clr-wins; that sample is discarded (not counted, not checked, not detected).

Reset
REQ-027 rst=0 SHALL immediately (asynchronously) force all counters, err_cnt, rd_cnt, trans_err, seq_det to 0, prev_valid to 0, P to 00, detector to IDLE.
REQ-028 rst asserted mid-sequence SHALL abandon any partial detection; no seq_det pulse may follow release.
REQ-029 After rst release, first accepted sample SHALL be treated as in REQ-016.

Verification
REQ-030 Reset: pulse rst=0 mid-run with counters nonzero -> all outputs 0 immediately, before next Clk edge.
REQ-031 Sequence: en=1, S=00,11,01,10 on 4 edges -> seq_det=1 for one cycle after 4th edge; rd_cnt=1 for each rd_sel; trans_err=0.
REQ-032 Illegal: S=00 then 01 -> trans_err=1, err_cnt=1; then S=01,10 (legal) -> trans_err still 1, err_cnt still 1.
REQ-033 Saturation (CW=8): S=00 for 300 accepted edges -> counter[00]=255, err_cnt=0.
REQ-034 Clear collision: counters nonzero, clr=1 with en=1 and S=11 -> counter[11]=0, all outputs 0; next sample S=10 not flagged.
REQ-035 Enable gap: S=00, then en=0 for 3 edges with S=01, then en=1 S=11,01,10 -> no error, seq_det pulses once, counter[01]=1.
